pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline stage for inter-stage registers (first user: EX->MEM).
//  - valid/ready handshake on both sides; optional 2-entry skid buffer.
//  - Synchronous flush that inserts a bubble.
//  - Control payload forced to zero whenever the stage holds no valid entry.
//  - Saturating stall counter for performance monitoring.
// PARAMETERS
//  DATA_W  101  datapath payload width (ALU_out, Store_Data, rd, PC_plus_4)
//  CTRL_W  8    control payload width (RegWrite, MemWrite, MemRead, WDSel, DMType); zeroed in bubbles
//  SKID_EN 1    1: 2-entry skid, registered o_ready, full throughput; 0: single entry, combinational o_ready
//  CNT_W   16   stall counter width
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  reset       in   1        asynchronous, active-low; clears all state immediately
//  i_valid     in   1        upstream entry valid
//  o_ready     out  1        stage can accept an entry this cycle
//  i_data      in   DATA_W   upstream datapath payload
//  i_ctrl      in   CTRL_W   upstream control payload
//  i_flush     in   1        synchronous kill of all held entries and of any same-cycle input
//  o_valid     out  1        downstream entry valid
//  i_ready     in   1        downstream accepts this cycle
//  o_data      out  DATA_W   head entry datapath payload
//  o_ctrl      out  CTRL_W   head entry control payload; 0 when !o_valid
//  o_occupancy out  2        entries held (0..2; max 1 when SKID_EN=0)
//  o_stall_cnt out  CNT_W    cycles with o_valid && !i_ready, saturating
// BEHAVIOUR
//  - Reset (reset==0): state EMPTY; o_valid=0, o_data=0, o_ctrl=0, o_occupancy=0, o_stall_cnt=0.
//    o_ready=1 once reset deasserts.
//  - Handshake:
//    - in_fire = i_valid && o_ready; out_fire = o_valid && i_ready.
//    - Accepted entry appears on o_* the next cycle (latency 1).
//    - Strict FIFO order.
//    - o_valid, once set, holds with stable o_data/o_ctrl until out_fire or flush.
//  - FSM (SKID_EN=1); main = head register, skid = second register:
//    - EMPTY: in_fire -> BUSY, main<=in.
//    - BUSY, in_fire && out_fire: main<=in, stay BUSY.
//    - BUSY, in_fire && !out_fire: skid<=in -> FULL.
//    - BUSY, out_fire only: -> EMPTY.
//    - FULL: o_ready=0; out_fire -> BUSY, main<=skid; otherwise hold.
//    - o_ready = (state != FULL); a registered decode, no combinational path from i_ready.
//  - SKID_EN=0: EMPTY/BUSY only; o_ready = !o_valid || i_ready (combinational); FULL unreachable.
//  - Flush:
//    - Highest priority. Next state EMPTY; main/skid valid cleared.
//    - Same-cycle in_fire is discarded.
//    - Same-cycle out_fire still counts as delivered downstream.
//  - Bubble: o_ctrl = o_valid ? main_ctrl : 0. o_data keeps its last value (don't-care).
//  - Stall counter: +1 per cycle with o_valid && !i_ready; saturates at 2^CNT_W-1; only reset clears it.
//  - o_occupancy: EMPTY=0, BUSY=1, FULL=2.
//  - i_valid may drop without acceptance; the stage must not latch in that case.
//  - Reset mid-operation drops all entries; no partial state survives.
// STRUCTURE
//  - Shared header pipe_defs.vh:
//    - state encodings ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2
//    - EXMEM_DATA_W=101, EXMEM_CTRL_W=8
//    - control field bit offsets (RegWrite[7], MemWrite[6], MemRead[5], WDSel[4:3], DMType[2:0])
//  - Sub-module pipe_entry: DATA_W+CTRL_W register with load enable, valid bit and async active-low clear.
//    Instantiated as main, plus skid when SKID_EN=1 (generate).
//  - FSM and stall counter live in the top module.
// TESTING
//  1. Reset, then i_valid=1 and i_ready=1 for 8 beats, data 0..7
//     -> o_data 0..7 one cycle later, one per cycle, o_ready stays 1.
//  2. Load A=0x11, hold i_ready=0, offer B=0x22
//     -> occupancy 2, o_ready=0, o_data=0x11.
//     Then i_ready=1 -> 0x11 then 0x22, occupancy 2->1->0.
//  3. Full stage with i_flush=1 and i_valid=1 (C=0x33)
//     -> next cycle o_valid=0, o_ctrl=0, occupancy 0; 0x33 never appears.
//  4. Stall with CNT_W=4, o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt=15 (saturated).
//  5. Assert reset low while FULL -> outputs zero immediately (no clock edge); after release o_ready=1.
//  6. SKID_EN=0, head valid, i_ready toggling 1/0
//     -> o_ready mirrors i_ready the same cycle; no entry lost or duplicated.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic inter-stage register.
//  - FSM state encoding (also the occupancy count: EMPTY=0, BUSY=1, FULL=2)
//  - EX->MEM payload widths used as the default stage widths
//  - EX->MEM control field layout
package pipe_stage_elastic_pkg;

  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // EX->MEM control payload, MSB first:
  // RegWrite[7], MemWrite[6], MemRead[5], WDSel[4:3], DMType[2:0]
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] wd_sel;
    logic [2:0] dm_type;
  } exmem_ctrl_t;

endpackage

// File: rtl/pipe_stage_elastic_entry.sv
// One held entry of the elastic stage: payload register with load enable
// plus a valid bit.
// Ports:
//  clk      rising-edge clock
//  reset    asynchronous active-low clear of valid and payload
//  i_load   capture i_d and set valid
//  i_clr    clear valid (wins over i_load)
//  i_d      payload in
//  o_valid  entry holds data
//  o_d      held payload
module pipe_stage_elastic_entry
  import pipe_stage_elastic_pkg::*;
#(
  parameter int W = EXMEM_DATA_W + EXMEM_CTRL_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_d
);

  logic         r_valid;
  logic [W-1:0] r_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_d     <= '0;
    end else begin
      if (i_clr)       r_valid <= 1'b0;
      else if (i_load) r_valid <= 1'b1;
      // payload only moves on load; a cleared entry keeps stale data
      if (i_load)      r_d <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_d     = r_d;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage (valid/ready both sides) with optional 2-entry skid,
// synchronous flush, bubble zeroing of control, saturating stall counter.
// Ports:
//  clk, reset          clock, asynchronous active-low reset
//  i_valid/o_ready     upstream handshake, i_data/i_ctrl payload
//  i_flush             kill held entries and any same-cycle input
//  o_valid/i_ready     downstream handshake, o_data/o_ctrl head payload
//  o_occupancy         entries held (0..2)
//  o_stall_cnt         cycles with o_valid && !i_ready, saturating
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W  = EXMEM_DATA_W,
  parameter int CTRL_W  = EXMEM_CTRL_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int EW = DATA_W + CTRL_W;

  pipe_state_e      r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  logic          w_in_fire, w_out_fire;
  logic          w_main_load, w_main_clr, w_skid_load, w_skid_clr;
  logic          w_main_vld, w_skid_vld;
  logic [EW-1:0] w_main_d, w_main_q, w_skid_q;

  // With the skid, ready is a decode of the state register only, so there is
  // no combinational path from i_ready. Without it, ready passes through.
  assign o_ready    = SKID_EN ? (r_state != ST_FULL) : (!w_main_vld || i_ready);
  assign w_in_fire  = i_valid && o_ready;
  assign w_out_fire = w_main_vld && i_ready;

  always_comb begin
    w_main_load = 1'b0;
    w_main_clr  = i_flush;
    w_skid_load = 1'b0;
    w_skid_clr  = i_flush;
    if (!i_flush) begin
      case (r_state)
        ST_EMPTY: w_main_load = w_in_fire;
        ST_BUSY: begin
          w_main_load = w_in_fire && w_out_fire;
          w_main_clr  = w_out_fire && !w_in_fire;
          w_skid_load = w_in_fire && !w_out_fire;
        end
        ST_FULL: begin
          // head drains, skid entry moves up
          w_main_load = w_out_fire;
          w_skid_clr  = w_out_fire;
        end
        default: ;
      endcase
    end
  end

  assign w_main_d = (r_state == ST_FULL) ? w_skid_q : {i_ctrl, i_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) r_state <= ST_BUSY;
        ST_BUSY: begin
          if (w_in_fire && !w_out_fire)      r_state <= SKID_EN ? ST_FULL : ST_BUSY;
          else if (!w_in_fire && w_out_fire) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_out_fire) r_state <= ST_BUSY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  pipe_stage_elastic_entry #(.W(EW)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_d     (w_main_d),
    .o_valid (w_main_vld),
    .o_d     (w_main_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_stage_elastic_entry #(.W(EW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_d     ({i_ctrl, i_data}),
        .o_valid (w_skid_vld),
        .o_d     (w_skid_q)
      );
    end else begin : g_no_skid
      assign w_skid_vld = 1'b0;
      assign w_skid_q   = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_main_vld && !i_ready && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign o_valid     = w_main_vld;
  assign o_data      = w_main_q[DATA_W-1:0];
  assign o_ctrl      = w_main_vld ? w_main_q[EW-1:DATA_W] : '0;
  assign o_occupancy = {1'b0, w_main_vld} + {1'b0, w_skid_vld};
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam int DW = 101;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [CW-1:0] i_ctrl = '0;

  // a_*: skid variant, 4-bit counter; b_*: single-entry variant
  logic          a_o_ready, a_o_valid, b_o_ready, b_o_valid;
  logic [DW-1:0] a_o_data, b_o_data;
  logic [CW-1:0] a_o_ctrl, b_o_ctrl;
  logic [1:0]    a_o_occ, b_o_occ;
  logic [3:0]    a_o_stall;
  logic [15:0]   b_o_stall;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(a_o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .i_flush(i_flush), .o_valid(a_o_valid),
    .i_ready(i_ready), .o_data(a_o_data), .o_ctrl(a_o_ctrl),
    .o_occupancy(a_o_occ), .o_stall_cnt(a_o_stall));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(b_o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .i_flush(i_flush), .o_valid(b_o_valid),
    .i_ready(i_ready), .o_data(b_o_data), .o_ctrl(b_o_ctrl),
    .o_occupancy(b_o_occ), .o_stall_cnt(b_o_stall));

  // Reference: each stage is a bounded FIFO (capacity 2 / 1)
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   sa, sb;
  int   checks = 0, errors = 0;

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // One clock: advance the reference from the inputs currently applied.
  task automatic step();
    bit   ra, rb, ina, inb, outa, outb, fl;
    ent_t e;
    ra   = qa.size() < 2;
    rb   = (qb.size() == 0) || i_ready;
    ina  = i_valid && ra;
    inb  = i_valid && rb;
    outa = (qa.size() > 0) && i_ready;
    outb = (qb.size() > 0) && i_ready;
    fl   = i_flush;
    e.d  = i_data;
    e.c  = i_ctrl;
    if (qa.size() > 0 && !i_ready && sa < 15)    sa++;
    if (qb.size() > 0 && !i_ready && sb < 65535) sb++;
    @(posedge clk);
    if (outa) void'(qa.pop_front());
    if (outb) void'(qb.pop_front());
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ina) qa.push_back(e);
      if (inb) qb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_data = '0; i_ctrl = '0;
    @(negedge clk);
    @(negedge clk);
    qa.delete(); qb.delete(); sa = 0; sb = 0;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", a_o_valid); end
    checks++; if (a_o_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", a_o_data); end
    checks++; if (a_o_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %0h want 0", a_o_ctrl); end
    checks++; if (a_o_occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", a_o_occ); end
    checks++; if (a_o_stall !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", a_o_stall); end
    checks++; if (a_o_ready !== 1'b1 || b_o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b/%0b want 1/1", a_o_ready, b_o_ready); end
  endtask

  task automatic test_stream();
    i_ready = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_data = DW'(k); i_ctrl = CW'(8'hA0 + k);
      #1;
      checks++; if (a_o_ready !== 1'b1 || b_o_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat %0d got %0b/%0b want 1/1", k, a_o_ready, b_o_ready); end
      step();
      checks++; if (a_o_valid !== 1'b1 || a_o_data !== DW'(k)) begin errors++; $display("FAIL stream_data_a beat %0d got v%0b %0h want v1 %0h", k, a_o_valid, a_o_data, k); end
      checks++; if (b_o_valid !== 1'b1 || b_o_data !== DW'(k)) begin errors++; $display("FAIL stream_data_b beat %0d got v%0b %0h want v1 %0h", k, b_o_valid, b_o_data, k); end
      checks++; if (a_o_ctrl !== CW'(8'hA0 + k)) begin errors++; $display("FAIL stream_ctrl beat %0d got %0h want %0h", k, a_o_ctrl, 8'hA0 + k); end
    end
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_skid();
    i_valid = 1'b1; i_ready = 1'b0; i_data = DW'(8'h11); i_ctrl = 8'h81;
    step();
    i_data = DW'(8'h22); i_ctrl = 8'h42;
    #1;
    checks++; if (a_o_ready !== 1'b1) begin errors++; $display("FAIL skid_busy_ready got %0b want 1", a_o_ready); end
    step();
    checks++; if (a_o_occ !== 2'd2) begin errors++; $display("FAIL skid_occ_full got %0d want 2", a_o_occ); end
    checks++; if (a_o_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %0b want 0", a_o_ready); end
    checks++; if (a_o_data !== DW'(8'h11)) begin errors++; $display("FAIL skid_head got %0h want 11", a_o_data); end
    i_valid = 1'b0; i_ready = 1'b1;
    step();
    checks++; if (a_o_data !== DW'(8'h22) || a_o_ctrl !== 8'h42) begin errors++; $display("FAIL skid_second got %0h/%0h want 22/42", a_o_data, a_o_ctrl); end
    checks++; if (a_o_occ !== 2'd1) begin errors++; $display("FAIL skid_occ_one got %0d want 1", a_o_occ); end
    step();
    checks++; if (a_o_occ !== 2'd0 || a_o_valid !== 1'b0 || a_o_ctrl !== '0) begin errors++; $display("FAIL skid_drained got occ%0d v%0b c%0h want 0 0 0", a_o_occ, a_o_valid, a_o_ctrl); end
  endtask

  task automatic test_flush();
    i_valid = 1'b1; i_ready = 1'b0; i_ctrl = 8'h5A;
    i_data = DW'(8'h0A); step();
    i_data = DW'(8'h0B); step();
    checks++; if (a_o_occ !== 2'd2) begin errors++; $display("FAIL flush_prefill got %0d want 2", a_o_occ); end
    i_flush = 1'b1; i_data = DW'(8'h33); i_ctrl = 8'hFF;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    checks++; if (a_o_valid !== 1'b0 || a_o_ctrl !== '0 || a_o_occ !== 2'd0) begin errors++; $display("FAIL flush_a got v%0b c%0h occ%0d want 0 0 0", a_o_valid, a_o_ctrl, a_o_occ); end
    checks++; if (b_o_valid !== 1'b0 || b_o_ctrl !== '0 || b_o_occ !== 2'd0) begin errors++; $display("FAIL flush_b got v%0b c%0h occ%0d want 0 0 0", b_o_valid, b_o_ctrl, b_o_occ); end
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (a_o_valid !== 1'b0 || b_o_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d got %0b/%0b want 0/0", k, a_o_valid, b_o_valid); end
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    i_valid = 1'b1; i_ready = 1'b0; i_data = DW'(8'h77); i_ctrl = 8'h01;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 9) begin
        checks++; if (a_o_stall !== 4'd10) begin errors++; $display("FAIL stall_mid got %0d want 10", a_o_stall); end
      end
    end
    checks++; if (a_o_stall !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d want 15", a_o_stall); end
    checks++; if (b_o_stall !== 16'd20) begin errors++; $display("FAIL stall_wide got %0d want 20", b_o_stall); end
  endtask

  task automatic test_async_reset();
    i_valid = 1'b1; i_ready = 1'b0; i_data = DW'(8'h55); i_ctrl = 8'hC3;
    step();
    checks++; if (a_o_occ !== 2'd2) begin errors++; $display("FAIL areset_prefill got %0d want 2", a_o_occ); end
    #2 reset = 1'b0;
    #1;
    checks++; if (a_o_valid !== 1'b0 || a_o_data !== '0 || a_o_ctrl !== '0) begin errors++; $display("FAIL areset_out got v%0b d%0h c%0h want 0", a_o_valid, a_o_data, a_o_ctrl); end
    checks++; if (a_o_occ !== 2'd0 || a_o_stall !== 4'd0) begin errors++; $display("FAIL areset_state got occ%0d st%0d want 0 0", a_o_occ, a_o_stall); end
    @(negedge clk);
    qa.delete(); qb.delete(); sa = 0; sb = 0;
    i_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (a_o_ready !== 1'b1 || b_o_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %0b/%0b want 1/1", a_o_ready, b_o_ready); end
  endtask

  task automatic test_noskid_toggle();
    i_valid = 1'b1; i_ready = 1'b0; i_data = DW'(8'h40); i_ctrl = 8'h10;
    step();
    for (int k = 0; k < 8; k++) begin
      i_ready = (k % 2 == 0);
      i_data  = DW'(8'h41 + k);
      #1;
      checks++; if (b_o_ready !== i_ready) begin errors++; $display("FAIL noskid_ready cycle %0d got %0b want %0b", k, b_o_ready, i_ready); end
      step();
      checks++; if (b_o_valid !== 1'b1 || b_o_data !== qb[0].d) begin errors++; $display("FAIL noskid_order cycle %0d got v%0b %0h want v1 %0h", k, b_o_valid, b_o_data, qb[0].d); end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(2) != 0);
      i_flush = ($urandom_range(15) == 0);
      i_data  = rnd_data();
      i_ctrl  = CW'($urandom);
      #1;
      checks++; if (a_o_ready !== (qa.size() < 2)) begin errors++; $display("FAIL rand_ready_a cyc %0d got %0b want %0b", n, a_o_ready, qa.size() < 2); end
      checks++; if (b_o_ready !== ((qb.size() == 0) || i_ready)) begin errors++; $display("FAIL rand_ready_b cyc %0d got %0b", n, b_o_ready); end
      step();
      checks++; if (a_o_valid !== (qa.size() > 0) || a_o_occ !== 2'(qa.size())) begin errors++; $display("FAIL rand_occ_a cyc %0d got v%0b occ%0d want occ%0d", n, a_o_valid, a_o_occ, qa.size()); end
      checks++; if (b_o_valid !== (qb.size() > 0) || b_o_occ !== 2'(qb.size())) begin errors++; $display("FAIL rand_occ_b cyc %0d got v%0b occ%0d want occ%0d", n, b_o_valid, b_o_occ, qb.size()); end
      checks++; if (a_o_ctrl !== ((qa.size() > 0) ? qa[0].c : CW'(0))) begin errors++; $display("FAIL rand_ctrl_a cyc %0d got %0h", n, a_o_ctrl); end
      checks++; if (b_o_ctrl !== ((qb.size() > 0) ? qb[0].c : CW'(0))) begin errors++; $display("FAIL rand_ctrl_b cyc %0d got %0h", n, b_o_ctrl); end
      if (qa.size() > 0) begin
        checks++; if (a_o_data !== qa[0].d) begin errors++; $display("FAIL rand_data_a cyc %0d got %0h want %0h", n, a_o_data, qa[0].d); end
      end
      if (qb.size() > 0) begin
        checks++; if (b_o_data !== qb[0].d) begin errors++; $display("FAIL rand_data_b cyc %0d got %0h want %0h", n, b_o_data, qb[0].d); end
      end
      checks++; if (a_o_stall !== 4'(sa) || b_o_stall !== 16'(sb)) begin errors++; $display("FAIL rand_stall cyc %0d got %0d/%0d want %0d/%0d", n, a_o_stall, b_o_stall, sa, sb); end
    end
    i_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall_sat();
    test_async_reset();
    test_noskid_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
